beam_scan_controller: RTL and testbench

//  Sequences the delay-and-sum beamformer through a 2-D grid of steering angles.
//  At each grid point: programs the angles, pulses the steering enable, waits out the delay-line refill,

---
 rtl/beam_scan_controller.sv | 213 +++++++++++++++++++++
 tb/tb_beam_scan_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_controller.sv
// rtl/beam_scan_controller.sv - 2-D steering-angle sweep with peak-energy (direction-of-arrival) search
//
// Steps the delay-and-sum beamformer through a raster of (hori, vert) steering
// angles. At each point the angles are applied, steer_en is pulsed, the delay
// line is allowed to refill, and |sample - midscale| is integrated. The point
// with the largest integrated energy is published when the sweep completes.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    begin a sweep (sampled only while idle)
//   abort                    stop the sweep (honoured whenever not idle)
//   sample_valid, beam_data  beamformer output stream (unsigned, midscale offset)
//   steer_en                 steering enable, high for STEER_PULSE cycles per point
//   steer_hori, steer_vert   current steering angles (7-bit signed)
//   busy                     sweep in progress
//   done                     1-cycle pulse, best_* valid and updated in that cycle
//   best_hori, best_vert     angle pair of the highest-energy point
//   best_energy              energy of that point
//
// Build option: define SCAN_CONTINUOUS_EN to restart the sweep automatically
// after each completed sweep; otherwise one sweep runs per start.

module beam_scan_controller #(
    parameter int BIT_WIDTH      = 8,
    parameter int ANGLE_MIN      = -27,
    parameter int ANGLE_MAX      = 27,
    parameter int ANGLE_STEP     = 9,
    parameter int STEER_PULSE    = 4,
    parameter int SETTLE_SAMPLES = 256,
    parameter int INTEG_SAMPLES  = 64,
    parameter int ACC_W          = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    sample_valid,
    input  logic [BIT_WIDTH-1:0]    beam_data,
    output logic                    steer_en,
    output logic signed [6:0]       steer_hori,
    output logic signed [6:0]       steer_vert,
    output logic                    busy,
    output logic                    done,
    output logic signed [6:0]       best_hori,
    output logic signed [6:0]       best_vert,
    output logic [ACC_W-1:0]        best_energy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STEER   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_INTEG   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic signed [7:0] A_MIN  = 8'(ANGLE_MIN);
    localparam logic signed [7:0] A_MAX  = 8'(ANGLE_MAX);
    localparam logic signed [7:0] A_STEP = 8'(ANGLE_STEP);

    localparam logic [15:0] STEER_LAST  = 16'(STEER_PULSE - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
    localparam logic [15:0] INTEG_LAST  = 16'(INTEG_SAMPLES - 1);

    localparam logic [BIT_WIDTH-1:0] MID = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic [2:0]              state;
    logic [15:0]             cnt;
    logic signed [7:0]       hori;
    logic signed [7:0]       vert;
    logic [ACC_W-1:0]        acc;
    logic                    first_pt;
    logic [ACC_W-1:0]        wb_energy;
    logic signed [6:0]       wb_hori;
    logic signed [6:0]       wb_vert;

    logic [BIT_WIDTH-1:0]    mag;
    logic [ACC_W:0]          sum;
    logic [ACC_W-1:0]        acc_sat;
    logic signed [7:0]       hori_nx;
    logic signed [7:0]       vert_nx;
    logic                    hori_wrap;
    logic                    vert_end;
    logic                    beats_best;

    always_comb begin
        mag        = (beam_data >= MID) ? (beam_data - MID) : (MID - beam_data);
        // One extra bit catches the carry so the accumulator clamps instead of wrapping.
        sum        = {1'b0, acc} + (ACC_W+1)'(mag);
        acc_sat    = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        hori_nx    = hori + A_STEP;
        vert_nx    = vert + A_STEP;
        hori_wrap  = (hori_nx > A_MAX);
        vert_end   = (vert_nx > A_MAX);
        // Strict compare: on a tie the earlier point in raster order is kept.
        beats_best = first_pt || (acc > wb_energy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hori        <= A_MIN;
            vert        <= A_MIN;
            acc         <= '0;
            first_pt    <= 1'b0;
            wb_energy   <= '0;
            wb_hori     <= '0;
            wb_vert     <= '0;
            best_hori   <= '0;
            best_vert   <= '0;
            best_energy <= '0;
        end else if (abort && (state != S_IDLE)) begin
            // Drop the sweep without publishing; best_* keep the last completed result.
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hori      <= A_MIN;
                        vert      <= A_MIN;
                        first_pt  <= 1'b1;
                        wb_energy <= '0;
                        wb_hori   <= '0;
                        wb_vert   <= '0;
                        cnt       <= '0;
                        state     <= S_STEER;
                    end
                end
                S_STEER: begin
                    if (cnt == STEER_LAST) begin
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (sample_valid) begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            acc   <= '0;
                            state <= S_INTEG;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                S_INTEG: begin
                    if (sample_valid) begin
                        acc <= acc_sat;
                        if (cnt == INTEG_LAST) begin
                            cnt   <= '0;
                            state <= S_COMPARE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                S_COMPARE: begin
                    if (beats_best) begin
                        wb_energy <= acc;
                        wb_hori   <= hori[6:0];
                        wb_vert   <= vert[6:0];
                    end
                    first_pt <= 1'b0;
                    state    <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (!hori_wrap) begin
                        hori  <= hori_nx;
                        state <= S_STEER;
                    end else if (!vert_end) begin
                        hori  <= A_MIN;
                        vert  <= vert_nx;
                        state <= S_STEER;
                    end else begin
                        // Publish on entry to DONE so best_* are valid while done is high.
                        best_energy <= wb_energy;
                        best_hori   <= wb_hori;
                        best_vert   <= wb_vert;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef SCAN_CONTINUOUS_EN
                    hori      <= A_MIN;
                    vert      <= A_MIN;
                    first_pt  <= 1'b1;
                    wb_energy <= '0;
                    wb_hori   <= '0;
                    wb_vert   <= '0;
                    cnt       <= '0;
                    state     <= S_STEER;
`else
                    state <= S_IDLE;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign steer_en   = (state == S_STEER);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign steer_hori = hori[6:0];
    assign steer_vert = vert[6:0];

endmodule

// File: tb/tb_beam_scan_controller.sv
// tb/tb_beam_scan_controller.sv - directed self-checking bench for beam_scan_controller

module tb_beam_scan_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start2 = 1'b0;
    logic abort2 = 1'b0;
    logic phase = 1'b0;
    logic valid_all = 1'b1;
    logic sample_valid;

    logic [7:0]        bd1;
    logic [7:0]        bd2;
    logic signed [6:0] hot_h = 7'sd0;
    logic signed [6:0] hot_v = 7'sd0;
    logic [7:0]        hot_val = 8'd128;
    logic [7:0]        base_val = 8'd128;

    logic              steer_en, busy, done;
    logic signed [6:0] steer_hori, steer_vert, best_hori, best_vert;
    logic [23:0]       best_energy;

    logic              steer_en2, busy2, done2;
    logic signed [6:0] steer_hori2, steer_vert2, best_hori2, best_vert2;
    logic [7:0]        best_energy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sample_valid = valid_all | phase;
    assign bd1 = (steer_hori == hot_h && steer_vert == hot_v) ? hot_val : base_val;
    assign bd2 = 8'd255;

    beam_scan_controller #(
        .BIT_WIDTH(8), .ANGLE_MIN(-9), .ANGLE_MAX(9), .ANGLE_STEP(9),
        .STEER_PULSE(4), .SETTLE_SAMPLES(4), .INTEG_SAMPLES(4), .ACC_W(24)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sample_valid(sample_valid), .beam_data(bd1),
        .steer_en(steer_en), .steer_hori(steer_hori), .steer_vert(steer_vert),
        .busy(busy), .done(done),
        .best_hori(best_hori), .best_vert(best_vert), .best_energy(best_energy)
    );

    beam_scan_controller #(
        .BIT_WIDTH(8), .ANGLE_MIN(-9), .ANGLE_MAX(9), .ANGLE_STEP(9),
        .STEER_PULSE(4), .SETTLE_SAMPLES(4), .INTEG_SAMPLES(4), .ACC_W(8)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .sample_valid(sample_valid), .beam_data(bd2),
        .steer_en(steer_en2), .steer_hori(steer_hori2), .steer_vert(steer_vert2),
        .busy(busy2), .done(done2),
        .best_hori(best_hori2), .best_vert(best_vert2), .best_energy(best_energy2)
    );

    // Observers of steering pulses and done pulses, sampled on the falling edge.
    int   pulse_total = 0;
    int   width_bad = 0;
    int   cur_w = 0;
    int   done_total = 0;
    int   pulse2_total = 0;
    int   rec_h [0:63];
    int   rec_v [0:63];
    logic en_q = 1'b0;
    logic en2_q = 1'b0;

    always @(negedge clk) begin
        phase <= ~phase;
        if (steer_en && !en_q) begin
            rec_h[pulse_total % 64] <= int'(steer_hori);
            rec_v[pulse_total % 64] <= int'(steer_vert);
            pulse_total <= pulse_total + 1;
            cur_w <= 1;
        end else if (steer_en) begin
            cur_w <= cur_w + 1;
        end
        if (!steer_en && en_q && cur_w != 4) width_bad <= width_bad + 1;
        en_q <= steer_en;
        if (done) done_total <= done_total + 1;
        if (steer_en2 && !en2_q) pulse2_total <= pulse2_total + 1;
        en2_q <= steer_en2;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    int p0, d0, p2, rises, n;
    logic prev;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_steer_en", steer_en, 0);
        check("rst_hori", steer_hori, -9);
        check("rst_vert", steer_vert, -9);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_hori", best_hori, 0);
        check("rst_best_vert", best_vert, 0);
        check("rst_best_energy", best_energy, 0);
        rst = 1'b0;
        @(negedge clk);

`ifndef SCAN_CONTINUOUS_EN
        // Single hot point at (9,-9); raster order and pulse shape
        base_val = 8'd128; hot_h = 7'sd9; hot_v = -7'sd9; hot_val = 8'd138; valid_all = 1'b1;
        p0 = pulse_total; d0 = done_total;
        pulse_start();
        check("t1_busy_after_start", busy, 1);
        wait_done("t1", 400);
        check("t1_best_hori", best_hori, 9);
        check("t1_best_vert", best_vert, -9);
        check("t1_best_energy", best_energy, 40);
        @(negedge clk);
        check("t1_busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        check("t1_done_count", done_total - d0, 1);
        check("t3_pulse_count", pulse_total - p0, 9);
        check("t3_pulse_width_errors", width_bad, 0);
        for (int k = 0; k < 9; k++) begin
            check("t3_seq_hori", rec_h[(p0 + k) % 64], -9 + 9 * (k % 3));
            check("t3_seq_vert", rec_v[(p0 + k) % 64], -9 + 9 * (k / 3));
        end

        // All points equal: the first point wins; sample_valid every other cycle
        base_val = 8'd138; hot_val = 8'd138; valid_all = 1'b0;
        pulse_start();
        wait_done("t2", 800);
        check("t2_best_hori", best_hori, -9);
        check("t2_best_vert", best_vert, -9);
        check("t2_best_energy", best_energy, 40);
        repeat (3) @(negedge clk);

        // Abort in INTEG of point 5 (0,0); hot value there must never be published
        base_val = 8'd128; hot_h = 7'sd0; hot_v = 7'sd0; hot_val = 8'd200; valid_all = 1'b1;
        d0 = done_total;
        rises = 0; prev = 1'b0; n = 0;
        start = 1'b1;
        while (rises < 5 && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (steer_en && !prev) rises++;
            prev = steer_en;
            n++;
        end
        check("t4_reached_point5", rises, 5);
        check("t4_point5_hori", steer_hori, 0);
        check("t4_point5_vert", steer_vert, 0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        check("t4_steer_en_after_abort", steer_en, 0);
        repeat (100) @(negedge clk);
        check("t4_no_done", done_total - d0, 0);
        check("t4_best_hori_kept", best_hori, -9);
        check("t4_best_vert_kept", best_vert, -9);
        check("t4_best_energy_kept", best_energy, 40);
`else
        // Continuous scanning: two sweeps with different data, then abort
        base_val = 8'd128; hot_h = 7'sd9; hot_v = -7'sd9; hot_val = 8'd138; valid_all = 1'b1;
        d0 = done_total;
        pulse_start();
        wait_done("t6_sweep1", 400);
        check("t6_s1_best_hori", best_hori, 9);
        check("t6_s1_best_vert", best_vert, -9);
        check("t6_s1_best_energy", best_energy, 40);
        hot_h = 7'sd0; hot_v = 7'sd9; hot_val = 8'd150;
        @(negedge clk);
        check("t6_busy_stays", busy, 1);
        check("t6_restart_steer", steer_en, 1);
        check("t6_restart_hori", steer_hori, -9);
        wait_done("t6_sweep2", 400);
        check("t6_s2_best_hori", best_hori, 0);
        check("t6_s2_best_vert", best_vert, 9);
        check("t6_s2_best_energy", best_energy, 88);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_busy_after_abort", busy, 0);
        repeat (5) @(negedge clk);
        check("t6_done_count", done_total - d0, 2);
`endif

        // Saturation with ACC_W=8, and start while busy ignored
        p2 = pulse2_total;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (30) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t5_done_seen", done2, 1);
        check("t5_best_energy_sat", best_energy2, 255);
        check("t5_best_hori", best_hori2, -9);
        check("t5_best_vert", best_vert2, -9);
        check("t5_pulse_count", pulse2_total - p2, 9);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        @(negedge clk);
        check("t5_idle_after", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
